// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcode encodings, FSM states and latched-operand bundle for the HI/LO unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  // Raw operands captured at accept, plus whether the op is signed.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
  } md_opnd_t;

endpackage

// File: rtl/div_core.sv
// div_core: iterative unsigned restoring divider working on operand magnitudes.
// Latency: start loads at one edge, then one quotient bit per edge for DIV_ITER edges; last flags the final one.
// Backpressure: none; abort stops iterating immediately, start is ignored while abort is high.
module div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic [5:0]  cnt;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  // One restoring step: shift the next dividend bit in and trial-subtract; bit 32 of diff is the borrow.
  always_comb begin
    rem_shift = {rem, quo[31]};
    diff      = rem_shift - {1'b0, dvs};
  end

  // Iteration state: quotient bits shift into quo as dividend bits shift out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= 6'(DIV_ITER);
    end else if (cnt != 6'd0) begin
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= rem_shift[31:0];
        quo <= {quo[30:0], 1'b0};
      end
      cnt <= cnt - 6'd1;
    end
  end

  assign last      = (cnt == 6'd1);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO owning HI/LO; MADD/MADDU/MSUB/MSUBU when MULDIV_MADD_EN is defined.
// Latency: MUL_LAT cycles for multiplies, 33 for divides (32 iterations + sign fix); MTHI/MTLO write at the next edge.
// Backpressure: busy is high while an op is in flight and new ops are ignored; cancel aborts and discards the result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  md_state_t   state, state_nxt;
  md_opnd_t    opnd;
  logic [1:0]  mul_cnt;
  logic        accept, is_mul, is_div, is_mthi, is_mtlo, op_sgn;
  logic        wr_res, div_start, div_last;
  logic [31:0] div_a_mag, div_b_mag, quo_mag, rem_mag;
  logic [63:0] mul_a_ext, mul_b_ext, product, res;
`ifdef MULDIV_MADD_EN
  logic        is_acc, is_sub, acc_q, sub_q;
`endif

  // Opcode decode; unknown or disabled opcodes decode to nothing.
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    op_sgn  = 1'b0;
`ifdef MULDIV_MADD_EN
    is_acc  = 1'b0;
    is_sub  = 1'b0;
`endif
    case (op)
      MD_MULT:  begin is_mul = 1'b1; op_sgn = 1'b1; end
      MD_MULTU: is_mul = 1'b1;
      MD_DIV:   begin is_div = 1'b1; op_sgn = 1'b1; end
      MD_DIVU:  is_div = 1'b1;
      MD_MTHI:  is_mthi = 1'b1;
      MD_MTLO:  is_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
      MD_MADD:  begin is_mul = 1'b1; op_sgn = 1'b1; is_acc = 1'b1; end
      MD_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
      MD_MSUB:  begin is_mul = 1'b1; op_sgn = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
      MD_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign accept    = op_valid && (state == ST_IDLE) && !cancel;
  assign div_a_mag = (op_sgn && src_a[31]) ? -src_a : src_a;
  assign div_b_mag = (op_sgn && src_b[31]) ? -src_b : src_b;

  div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (cancel),
    .dividend  (div_a_mag),
    .divisor   (div_b_mag),
    .quotient  (quo_mag),
    .remainder (rem_mag),
    .last      (div_last)
  );

  // Next state and result-write strobe; cancel beats every transition, including completion.
  always_comb begin
    state_nxt = state;
    wr_res    = 1'b0;
    div_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul) begin
          state_nxt = ST_MUL;
        end else if (accept && is_div) begin
          state_nxt = ST_DIV;
          div_start = 1'b1;
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_nxt = ST_IDLE;
        end else if (mul_cnt == 2'd0) begin
          wr_res    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (cancel)        state_nxt = ST_IDLE;
        else if (div_last) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        state_nxt = ST_IDLE;
        wr_res    = !cancel;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered busy/done so both are glitch-free for the hazard controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= wr_res;
    end
  end

  // Operand capture at accept and multiply latency countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd    <= '0;
      mul_cnt <= '0;
`ifdef MULDIV_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else if (accept && (is_mul || is_div)) begin
      opnd    <= '{a: src_a, b: src_b, sgn: op_sgn};
      mul_cnt <= 2'(MUL_LAT - 1);
`ifdef MULDIV_MADD_EN
      acc_q   <= is_acc;
      sub_q   <= is_sub;
`endif
    end else if (state == ST_MUL && mul_cnt != 2'd0) begin
      mul_cnt <= mul_cnt - 2'd1;
    end
  end

  // Result select: product (optionally accumulated into the live HI/LO) or sign-fixed divide result.
  always_comb begin
    mul_a_ext = {{32{opnd.sgn & opnd.a[31]}}, opnd.a};
    mul_b_ext = {{32{opnd.sgn & opnd.b[31]}}, opnd.b};
    product   = mul_a_ext * mul_b_ext;
    res       = product;
`ifdef MULDIV_MADD_EN
    if (acc_q) res = sub_q ? ({hi, lo} - product) : ({hi, lo} + product);
`endif
    if (state == ST_FIX) begin
      if (opnd.b == '0) begin
        res = {opnd.a, 32'hFFFF_FFFF};
      end else begin
        res = {(opnd.sgn && opnd.a[31]) ? -rem_mag : rem_mag,
               (opnd.sgn && (opnd.a[31] ^ opnd.b[31])) ? -quo_mag : quo_mag};
      end
    end
  end

  // Architectural HI/LO: written by a completing op or directly by MTHI/MTLO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_res) begin
      {hi, lo} <= res;
    end else begin
      if (accept && is_mthi) hi <= src_a;
      if (accept && is_mtlo) lo <= src_a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [3:0]  op = MD_NOP;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        cancel = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  // Present an op at the current negedge, hold it across one rising edge, then scramble the operands.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; op = MD_NOP; src_a = 32'hDEAD_BEEF; src_b = 32'hCAFE_F00D;
    @(negedge clk);
  endtask

  // Count busy cycles (starting in the cycle after accept) until busy drops, bounded.
  task automatic run_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); else passed++;
    total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo: hi=%h lo=%h want 0 0", hi, lo); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu();
    int n;
    issue(MD_DIVU, 32'd100, 32'd7);
    run_busy(n);
    total++; if (n != 33) $display("FAIL divu_busy_cycles: got %0d want 33", n); else passed++;
    total++; if (done !== 1'b1) $display("FAIL divu_done: got %b want 1", done); else passed++;
    total++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_result: hi=%h lo=%h want 2 e", hi, lo); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL divu_done_pulse: got %b want 0", done); else passed++;
  endtask

  task automatic test_div_signed();
    int n;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_busy(n);
    total++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) $display("FAIL div_neg7_by_2: hi=%h lo=%h want ffffffff fffffffd", hi, lo); else passed++;
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy(n);
    total++; if (lo !== 32'h8000_0000 || hi !== 32'h0) $display("FAIL div_overflow: hi=%h lo=%h want 0 80000000", hi, lo); else passed++;
  endtask

  task automatic test_mult();
    int n;
    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    run_busy(n);
    total++; if (n != 2) $display("FAIL mult_busy_cycles: got %0d want 2", n); else passed++;
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE || done !== 1'b1) $display("FAIL mult_result: hi=%h lo=%h done=%b want ffffffff fffffffe 1", hi, lo, done); else passed++;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_busy(n);
    total++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) $display("FAIL multu_result: hi=%h lo=%h want 1 fffffffe", hi, lo); else passed++;
  endtask

  task automatic test_div_zero_mthi();
    int n;
    issue(MD_DIVU, 32'd9, 32'd0);
    run_busy(n);
    total++; if (n != 33) $display("FAIL divu_zero_cycles: got %0d want 33", n); else passed++;
    total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd9) $display("FAIL divu_zero_result: hi=%h lo=%h want 9 ffffffff", hi, lo); else passed++;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd0);
    run_busy(n);
    total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9) $display("FAIL div_zero_result: hi=%h lo=%h want fffffff9 ffffffff", hi, lo); else passed++;
    issue(MD_MTHI, 32'h1234, 32'd0);
    total++; if (hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) $display("FAIL mthi: hi=%h busy=%b done=%b want 1234 0 0", hi, busy, done); else passed++;
  endtask

  task automatic test_nop_ops();
    issue(MD_MTHI, 32'h55, 32'd0);
    issue(MD_MTLO, 32'h66, 32'd0);
    issue(4'hF, 32'd3, 32'd4);
    total++; if (busy !== 1'b0 || hi !== 32'h55 || lo !== 32'h66) $display("FAIL unknown_op: busy=%b hi=%h lo=%h want 0 55 66", busy, hi, lo); else passed++;
`ifndef MULDIV_MADD_EN
    issue(MD_MADDU, 32'd3, 32'd4);
    @(negedge clk);
    total++; if (busy !== 1'b0 || hi !== 32'h55 || lo !== 32'h66) $display("FAIL madd_disabled: busy=%b hi=%h lo=%h want 0 55 66", busy, hi, lo); else passed++;
`endif
  endtask

  task automatic test_cancel();
    int n;
    issue(MD_MTHI, 32'hA, 32'd0);
    issue(MD_MTLO, 32'hB, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL cancel_pre_busy: got %b want 1", busy); else passed++;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hA || lo !== 32'hB) $display("FAIL cancel_busy: busy=%b done=%b hi=%h lo=%h want 0 0 a b", busy, done, hi, lo); else passed++;
    issue(MD_DIVU, 32'd100, 32'd7);
    run_busy(n);
    total++; if (n != 33 || lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_after_cancel: cycles=%0d hi=%h lo=%h want 33 2 e", n, hi, lo); else passed++;
    op = MD_MULT; src_a = 32'd5; src_b = 32'd5; op_valid = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; cancel = 1'b0; op = MD_NOP;
    @(negedge clk);
    total++; if (busy !== 1'b0 || lo !== 32'd14) $display("FAIL cancel_with_issue: busy=%b lo=%h want 0 e", busy, lo); else passed++;
    issue(MD_MULTU, 32'd5, 32'd5);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) $display("FAIL cancel_at_completion: busy=%b done=%b hi=%h lo=%h want 0 0 2 e", busy, done, hi, lo); else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    issue(MD_DIVU, 32'd100, 32'd7);
    run_busy(n);
    total++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done); else passed++;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_busy(n);
    total++; if (n != 2 || hi !== 32'h1 || lo !== 32'hFFFF_FFFE) $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h want 2 1 fffffffe", n, hi, lo); else passed++;
  endtask

  task automatic test_async_reset();
    int n;
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(MD_MULTU, 32'd3, 32'd4);
    run_busy(n);
    total++; if (n != 2 || lo !== 32'd12 || hi !== 32'd0) $display("FAIL after_reset_mul: cycles=%0d hi=%h lo=%h want 2 0 c", n, hi, lo); else passed++;
  endtask

`ifdef MULDIV_MADD_EN
  task automatic test_madd();
    int n;
    issue(MD_MTHI, 32'h0, 32'd0);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue(MD_MADDU, 32'd3, 32'd4);
    run_busy(n);
    total++; if (n != 2 || hi !== 32'h1 || lo !== 32'hB) $display("FAIL maddu: cycles=%0d hi=%h lo=%h want 2 1 b", n, hi, lo); else passed++;
    issue(MD_MSUB, 32'hFFFF_FFFF, 32'd2);
    run_busy(n);
    total++; if (hi !== 32'h1 || lo !== 32'hD) $display("FAIL msub: hi=%h lo=%h want 1 d", hi, lo); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_mult();
    test_div_zero_mthi();
    test_nop_ops();
    test_cancel();
    test_back_to_back();
    test_async_reset();
`ifdef MULDIV_MADD_EN
    test_madd();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
